// File: rtl/tpu_job_sequencer.sv
// Job sequencer for the TPU top level: weight reload, UB row streaming and result-capture window.
// Optional perf counters are enabled with `define TPU_JOB_SEQUENCER_PERF_CNT_EN.
module tpu_job_sequencer #(
  parameter int ADDRESSSIZE      = 10,
  parameter int ADDRESSSIZE_fifo = 2,
  parameter int MATRIX_SIZE      = 64,
  parameter int WLOAD_CYCLES     = 2,
  parameter int RESULT_LAT       = 130
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [ADDRESSSIZE-1:0]      cfg_base_addr,
  input  logic [ADDRESSSIZE-1:0]      cfg_num_rows,
  input  logic [ADDRESSSIZE_fifo-1:0] cfg_w_sel,
  output logic [ADDRESSSIZE-1:0]      sram_address,
  output logic [ADDRESSSIZE_fifo-1:0] fifo_address,
  output logic                        we_rl,
  output logic                        valid_address,
  output logic                        busy,
  output logic                        done,
  output logic                        err
`ifdef TPU_JOB_SEQUENCER_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_cycles,
  output logic [15:0]                 perf_jobs
`endif
);

  // Tick width leaves headroom above RESULT_LAT + MATRIX_SIZE so it never wraps.
  localparam int TW = ADDRESSSIZE + 9;
  localparam int WW = $clog2(WLOAD_CYCLES + 1);
  localparam logic [TW-1:0] MAX_ROWS = TW'(MATRIX_SIZE);
  localparam logic [TW-1:0] RL_T     = TW'(RESULT_LAT);
  localparam logic [WW-1:0] WL_LAST  = WW'(WLOAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WLOAD, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q, rows_q;
  logic [TW-1:0]          tick_q;
  logic [WW-1:0]          wl_cnt_q;

  logic [TW-1:0] rows_ext, last_tick, tick_nxt;
  logic          cfg_legal, accept, wl_last, run_last;

  function automatic logic in_win(input logic [TW-1:0] t, input logic [TW-1:0] n);
    return (t >= RL_T) && (t < RL_T + n);
  endfunction

  assign rows_ext  = TW'(rows_q);
  assign last_tick = RL_T + rows_ext - TW'(1);
  assign tick_nxt  = tick_q + TW'(1);
  assign cfg_legal = (cfg_num_rows != '0) && (TW'(cfg_num_rows) <= MAX_ROWS);
  assign accept    = (state_q == IDLE) && start && cfg_legal;
  assign wl_last   = (wl_cnt_q == WL_LAST);
  assign run_last  = (tick_q == last_tick);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = WLOAD;
      WLOAD:   if (wl_last)  state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q        <= '0;
      rows_q        <= '0;
      tick_q        <= '0;
      wl_cnt_q      <= '0;
      sram_address  <= '0;
      fifo_address  <= '0;
      we_rl         <= 1'b0;
      valid_address <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_q       <= cfg_base_addr;
            rows_q       <= cfg_num_rows;
            fifo_address <= cfg_w_sel;
            busy         <= 1'b1;
            we_rl        <= 1'b1;
            wl_cnt_q     <= '0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        WLOAD: begin
          if (wl_last) begin
            we_rl         <= 1'b0;
            tick_q        <= '0;
            sram_address  <= base_q;
            valid_address <= !in_win('0, rows_ext);
          end else begin
            wl_cnt_q <= wl_cnt_q + WW'(1);
          end
        end
        RUN: begin
          if (run_last) begin
            done          <= 1'b1;
            valid_address <= 1'b1;
          end else begin
            tick_q <= tick_nxt;
            // Address issue and capture window advance independently off the same tick.
            if (tick_nxt < rows_ext)
              sram_address <= base_q + tick_nxt[ADDRESSSIZE-1:0];
            valid_address <= !in_win(tick_nxt, rows_ext);
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef TPU_JOB_SEQUENCER_PERF_CNT_EN
  logic [31:0] job_cyc_q;

  // job_cyc_q already counts the accept cycle; DONE adds the final one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      job_cyc_q   <= '0;
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) job_cyc_q <= 32'd1;
        WLOAD, RUN: if (job_cyc_q != '1) job_cyc_q <= job_cyc_q + 32'd1;
        DONE: begin
          perf_cycles <= (job_cyc_q == '1) ? '1 : job_cyc_q + 32'd1;
          perf_jobs   <= perf_jobs + 16'd1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Bench for tpu_job_sequencer: two instances (RESULT_LAT 10 and 2) against an offset-based job model.
module tb_tpu_job_sequencer;
  localparam int AW  = 10;
  localparam int FW  = 2;
  localparam int MS  = 4;
  localparam int WL  = 2;
  localparam int RLA = 10;
  localparam int RLB = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [AW-1:0] cfg_num_rows = '0;
  logic [FW-1:0] cfg_w_sel = '0;

  logic [1:0][AW-1:0] sram;
  logic [1:0][FW-1:0] fifo;
  logic [1:0] we, va, busy, done, err;
`ifdef TPU_JOB_SEQUENCER_PERF_CNT_EN
  logic [1:0][31:0] pcyc;
  logic [1:0][15:0] pjobs;
`endif

  always #5 clk = ~clk;

  tpu_job_sequencer #(.ADDRESSSIZE(AW), .ADDRESSSIZE_fifo(FW), .MATRIX_SIZE(MS),
                      .WLOAD_CYCLES(WL), .RESULT_LAT(RLA)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_rows(cfg_num_rows), .cfg_w_sel(cfg_w_sel), .sram_address(sram[0]),
    .fifo_address(fifo[0]), .we_rl(we[0]), .valid_address(va[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
`ifdef TPU_JOB_SEQUENCER_PERF_CNT_EN
    , .perf_cycles(pcyc[0]), .perf_jobs(pjobs[0])
`endif
  );

  tpu_job_sequencer #(.ADDRESSSIZE(AW), .ADDRESSSIZE_fifo(FW), .MATRIX_SIZE(MS),
                      .WLOAD_CYCLES(WL), .RESULT_LAT(RLB)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_rows(cfg_num_rows), .cfg_w_sel(cfg_w_sel), .sram_address(sram[1]),
    .fifo_address(fifo[1]), .we_rl(we[1]), .valid_address(va[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
`ifdef TPU_JOB_SEQUENCER_PERF_CNT_EN
    , .perf_cycles(pcyc[1]), .perf_jobs(pjobs[1])
`endif
  );

  // Model: k = cycles since the accept cycle; every output follows from k and the job.
  bit          act [2];
  int          k [2], mb [2], mn [2], mperf [2], mjobs [2];
  logic [AW-1:0] msram [2];
  logic [FW-1:0] mfifo [2];
  bit          merr [2];
  int          nchk = 0;
  int          nerr = 0;

  function automatic int rl_of(input int i);
    return (i == 0) ? RLA : RLB;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; k[i] = 0; mb[i] = 0; mn[i] = 0; mperf[i] = 0; mjobs[i] = 0;
      msram[i] = '0; mfifo[i] = '0; merr[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      merr[i] = 0;
      if (!act[i]) begin
        if (start) begin
          if (cfg_num_rows >= 1 && int'(cfg_num_rows) <= MS) begin
            act[i] = 1; k[i] = 1; mb[i] = int'(cfg_base_addr);
            mn[i] = int'(cfg_num_rows); mfifo[i] = cfg_w_sel;
          end else merr[i] = 1;
        end
      end else begin
        k[i]++;
        if (k[i] == WL + rl_of(i) + mn[i] + 2) begin
          act[i] = 0; mjobs[i]++; mperf[i] = k[i];
        end
      end
      if (act[i] && k[i] - 1 - WL >= 0 && k[i] - 1 - WL < mn[i])
        msram[i] = AW'(mb[i] + k[i] - 1 - WL);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int t;
      logic e_we, e_va, e_done;
      t      = k[i] - 1 - WL;
      e_we   = act[i] && k[i] >= 1 && k[i] <= WL;
      e_va   = !(act[i] && t >= rl_of(i) && t < rl_of(i) + mn[i]);
      e_done = act[i] && (k[i] == WL + rl_of(i) + mn[i] + 1);
      chk("sram_address", i, 32'(sram[i]), 32'(msram[i]));
      chk("fifo_address", i, 32'(fifo[i]), 32'(mfifo[i]));
      chk("we_rl", i, 32'(we[i]), 32'(e_we));
      chk("valid_address", i, 32'(va[i]), 32'(e_va));
      chk("busy", i, 32'(busy[i]), 32'(act[i]));
      chk("done", i, 32'(done[i]), 32'(e_done));
      chk("err", i, 32'(err[i]), 32'(merr[i]));
`ifdef TPU_JOB_SEQUENCER_PERF_CNT_EN
      chk("perf_cycles", i, pcyc[i], 32'(mperf[i]));
      chk("perf_jobs", i, 32'(pjobs[i]), 32'(mjobs[i] & 16'hFFFF));
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int base, rows, wsel;
    bit exp_err;
    int exp_done_a, exp_done_b, exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // done offsets are counted from the accept cycle: WLOAD_CYCLES + RESULT_LAT + rows + 1
    vecs[0] = '{5,    4, 2, 0, 17, 9, 8};
    vecs[1] = '{1022, 3, 1, 0, 16, 8, 0};
    vecs[2] = '{0,    0, 3, 1, 0,  0, 0};
    vecs[3] = '{0,    5, 3, 1, 0,  0, 0};
    vecs[4] = '{100,  1, 3, 0, 14, 6, 100};
    vecs[5] = '{1023, 4, 0, 0, 17, 9, 2};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rstn = 1'b1;

    foreach (vecs[j]) begin
      int dA, dB;
      bit es;
      cfg_base_addr = AW'(vecs[j].base);
      cfg_num_rows  = AW'(vecs[j].rows);
      cfg_w_sel     = FW'(vecs[j].wsel);
      start = 1'b1;
      cyc();
      start = 1'b0;
      es = err[0];
      dA = 0; dB = 0;
      for (int c = 2; c <= 60; c++) begin
        cyc();
        if (done[0]) dA = c;
        if (done[1]) dB = c;
        if (!busy[0] && !busy[1] && !act[0] && !act[1]) break;
      end
      chk("vec_err", j, 32'(es), 32'(vecs[j].exp_err));
      chk("vec_done_a", j, 32'(dA), 32'(vecs[j].exp_done_a));
      chk("vec_done_b", j, 32'(dB), 32'(vecs[j].exp_done_b));
      chk("vec_last_sram_a", j, 32'(sram[0]), 32'(vecs[j].exp_last));
      chk("vec_last_sram_b", j, 32'(sram[1]), 32'(vecs[j].exp_last));
    end

    // Second start during RUN must be dropped.
    begin
      int nd0, nd1;
      cfg_base_addr = 10; cfg_num_rows = 2; cfg_w_sel = 1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      nd0 = 0; nd1 = 0;
      for (int c = 2; c <= 40; c++) begin
        if (c == 5) begin
          start = 1'b1; cfg_num_rows = 3; cfg_base_addr = 200;
        end else start = 1'b0;
        cyc();
        nd0 += int'(done[0]);
        nd1 += int'(done[1]);
        if (c > 5 && !busy[0] && !busy[1] && !act[0] && !act[1]) break;
      end
      start = 1'b0;
      chk("busy_start_done_count", 0, 32'(nd0), 32'd1);
      chk("busy_start_done_count", 1, 32'(nd1), 32'd1);
    end

    // Reset during WLOAD aborts at once with no done.
    begin
      int nd;
      cfg_base_addr = 3; cfg_num_rows = 4; cfg_w_sel = 3;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("wload_we_rl_before_reset", 0, 32'(we[0]), 32'd1);
      #2 rstn = 1'b0;
      #1 model_reset();
      check_all();
      cyc();
      cyc();
      rstn = 1'b1;
      nd = 0;
      for (int c = 0; c < 25; c++) begin
        cyc();
        nd += int'(done[0]) + int'(done[1]);
      end
      chk("reset_no_done", 0, 32'(nd), 32'd0);
    end

    for (int c = 0; c < 500; c++) begin
      start         = ($urandom_range(0, 3) == 0);
      cfg_num_rows  = AW'($urandom_range(0, 5));
      cfg_base_addr = AW'($urandom);
      cfg_w_sel     = FW'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
